// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter that shares one single-ported TCDM bank between NumIn masters.
// The response pipe returns read data (and optionally write acks) to the master that issued the access.
module tcdm_bank_rr_arbiter #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned AddrMemWidth = 12,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RespLat      = 1,
    parameter bit          WriteRespEn  = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NumIn-1:0]                         req_i,
    input  logic [NumIn-1:0][AddrMemWidth-1:0]       add_i,
    input  logic [NumIn-1:0]                         wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]          wdata_i,
    input  logic [NumIn-1:0][DataWidth/8-1:0]        be_i,
    output logic [NumIn-1:0]                         gnt_o,
    output logic [NumIn-1:0]                         vld_o,
    output logic [NumIn-1:0][DataWidth-1:0]          rdata_o,
    output logic                                     req_o,
    input  logic                                     gnt_i,
    output logic [AddrMemWidth-1:0]                  add_o,
    output logic                                     wen_o,
    output logic [DataWidth-1:0]                     wdata_o,
    output logic [DataWidth/8-1:0]                   be_o,
    input  logic [DataWidth-1:0]                     rdata_i
);

    localparam int unsigned PtrW = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [PtrW-1:0]      rr_q;
    logic [PtrW-1:0]      rr_d;
    logic [PtrW-1:0]      winner;
    logic [2*NumIn-1:0]   req_rot;
    logic                 handshake;

    logic                 pipe_vld_q [RespLat];
    logic [PtrW-1:0]      pipe_idx_q [RespLat];
    logic                 pipe_wr_q  [RespLat];

    // Rotate the requests so that bit 0 is the current priority holder; the lowest set bit wins.
    always_comb begin
        int cand;
        winner  = '0;
        cand    = 0;
        req_rot = {req_i, req_i} >> rr_q;
        for (int k = NumIn - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                cand = int'(rr_q) + k;
                if (cand >= int'(NumIn)) begin
                    cand = cand - int'(NumIn);
                end
                winner = PtrW'(cand);
            end
        end
    end

    assign req_o     = |req_i;
    assign handshake = req_o & gnt_i;
    assign add_o     = add_i[winner];
    assign wen_o     = wen_i[winner];
    assign wdata_o   = wdata_i[winner];
    assign be_o      = be_i[winner];

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[winner] = 1'b1;
        end
    end

    // Priority only moves on an accepted transfer, so a stalled bank keeps the same winner.
    always_comb begin
        rr_d = rr_q;
        if (handshake) begin
            rr_d = (winner == PtrW'(NumIn - 1)) ? '0 : winner + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RespLat; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= '0;
                pipe_wr_q[i]  <= 1'b0;
            end
        end else begin
            pipe_vld_q[0] <= handshake;
            pipe_idx_q[0] <= winner;
            pipe_wr_q[0]  <= wen_o;
            for (int i = 1; i < RespLat; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
                pipe_wr_q[i]  <= pipe_wr_q[i-1];
            end
        end
    end

    // Only the owning master's lane carries data; the others are held at zero.
    always_comb begin
        vld_o   = '0;
        rdata_o = '0;
        if (pipe_vld_q[RespLat-1] && (!pipe_wr_q[RespLat-1] || WriteRespEn)) begin
            vld_o[pipe_idx_q[RespLat-1]]   = 1'b1;
            rdata_o[pipe_idx_q[RespLat-1]] = rdata_i;
        end
    end

`ifndef SYNTHESIS
    logic hs_hist_q [RespLat];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RespLat; i++) begin
                hs_hist_q[i] <= 1'b0;
            end
        end else begin
            hs_hist_q[0] <= handshake;
            for (int i = 1; i < RespLat; i++) begin
                hs_hist_q[i] <= hs_hist_q[i-1];
            end
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(gnt_o));
            assert ((gnt_o & ~req_i) == '0);
            if (|vld_o) begin
                assert (hs_hist_q[RespLat-1]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// Directed bench for tcdm_bank_rr_arbiter: four instances share one stimulus stream and differ
// only in RespLat/WriteRespEn (0: 1/1, 1: 1/0, 2: 3/1, 3: 2/1).
module tb_tcdm_bank_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0]            req;
    logic [N-1:0]            wen;
    logic [N-1:0][AW-1:0]    add;
    logic [N-1:0][DW-1:0]    wdata;
    logic [N-1:0][BW-1:0]    be;
    logic                    gnt_in;
    logic [DW-1:0]           rdata_in;

    logic [N-1:0]            gnt_w   [4];
    logic [N-1:0]            vld_w   [4];
    logic [N-1:0][DW-1:0]    rdata_w [4];
    logic                    req_w   [4];
    logic                    wen_w   [4];
    logic [AW-1:0]           add_w   [4];
    logic [DW-1:0]           wdata_w [4];
    logic [BW-1:0]           be_w    [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tcdm_bank_rr_arbiter #(
            .NumIn       (N),
            .AddrMemWidth(AW),
            .DataWidth   (DW),
            .RespLat     ((g == 2) ? 3 : ((g == 3) ? 2 : 1)),
            .WriteRespEn (g != 1)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .req_i  (req),
            .add_i  (add),
            .wen_i  (wen),
            .wdata_i(wdata),
            .be_i   (be),
            .gnt_o  (gnt_w[g]),
            .vld_o  (vld_w[g]),
            .rdata_o(rdata_w[g]),
            .req_o  (req_w[g]),
            .gnt_i  (gnt_in),
            .add_o  (add_w[g]),
            .wen_o  (wen_w[g]),
            .wdata_o(wdata_w[g]),
            .be_o   (be_w[g]),
            .rdata_i(rdata_in)
        );
    end

    typedef struct {
        logic [N-1:0]  req;
        logic          gnt;
        logic [DW-1:0] rdata;
        logic [N-1:0]  exp_gnt;
        logic          exp_req;
        logic [AW-1:0] exp_add;
        logic [N-1:0]  exp_vld;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mkVec(logic [N-1:0] r, logic g, logic [N-1:0] eg, logic er,
                                   logic [AW-1:0] ea, logic [N-1:0] ev);
        vec_t v;
        v.req     = r;
        v.gnt     = g;
        v.rdata   = '0;
        v.exp_gnt = eg;
        v.exp_req = er;
        v.exp_add = ea;
        v.exp_vld = ev;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] expRdata(logic [N-1:0] v, logic [DW-1:0] d);
        logic [N*DW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (v[k]) r[k*DW +: DW] = d;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic g, input logic [N-1:0] w,
                                 input logic [DW-1:0] d);
        req      = r;
        gnt_in   = g;
        wen      = w;
        rdata_in = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fairness, bank stall, then the master-2 read returning 0xDEADBEEF in vector 14.
        tbl[0]  = mkVec(4'b0000, 1'b1, 4'b0000, 1'b0, 12'h010, 4'b0000);
        tbl[1]  = mkVec(4'b1111, 1'b1, 4'b0001, 1'b1, 12'h010, 4'b0000);
        tbl[2]  = mkVec(4'b1111, 1'b1, 4'b0010, 1'b1, 12'h011, 4'b0001);
        tbl[3]  = mkVec(4'b1111, 1'b1, 4'b0100, 1'b1, 12'h005, 4'b0010);
        tbl[4]  = mkVec(4'b1111, 1'b1, 4'b1000, 1'b1, 12'h013, 4'b0100);
        tbl[5]  = mkVec(4'b1111, 1'b1, 4'b0001, 1'b1, 12'h010, 4'b1000);
        tbl[6]  = mkVec(4'b1111, 1'b1, 4'b0010, 1'b1, 12'h011, 4'b0001);
        tbl[7]  = mkVec(4'b1111, 1'b1, 4'b0100, 1'b1, 12'h005, 4'b0010);
        tbl[8]  = mkVec(4'b1111, 1'b1, 4'b1000, 1'b1, 12'h013, 4'b0100);
        tbl[9]  = mkVec(4'b0110, 1'b0, 4'b0000, 1'b1, 12'h011, 4'b1000);
        tbl[10] = mkVec(4'b0110, 1'b0, 4'b0000, 1'b1, 12'h011, 4'b0000);
        tbl[11] = mkVec(4'b0110, 1'b0, 4'b0000, 1'b1, 12'h011, 4'b0000);
        tbl[12] = mkVec(4'b0110, 1'b1, 4'b0010, 1'b1, 12'h011, 4'b0000);
        tbl[13] = mkVec(4'b0110, 1'b1, 4'b0100, 1'b1, 12'h005, 4'b0010);
        tbl[14] = mkVec(4'b0101, 1'b1, 4'b0001, 1'b1, 12'h010, 4'b0100);
        tbl[15] = mkVec(4'b1010, 1'b1, 4'b0010, 1'b1, 12'h011, 4'b0001);
        tbl[16] = mkVec(4'b0000, 1'b1, 4'b0000, 1'b0, 12'h010, 4'b0010);
        tbl[17] = mkVec(4'b0000, 1'b1, 4'b0000, 1'b0, 12'h010, 4'b0000);
        for (int i = 0; i < 18; i++) begin
            tbl[i].rdata = (i == 14) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
        end

        rst_n    = 1'b0;
        req      = '0;
        wen      = '0;
        gnt_in   = 1'b0;
        rdata_in = 32'hFFFF_FFFF;
        add      = {12'h013, 12'h005, 12'h011, 12'h010};
        wdata    = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        be       = {4'h8, 4'h4, 4'h2, 4'h1};

        #2;
        checkOutput("reset vld",   128'(vld_w[0]),   '0);
        checkOutput("reset rdata", rdata_w[0],       '0);
        checkOutput("reset req_o", 128'(req_w[0]),   '0);
        checkOutput("reset gnt",   128'(gnt_w[0]),   '0);
        checkOutput("reset vld D", 128'(vld_w[3]),   '0);
        #10;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].req, tbl[i].gnt, '0, tbl[i].rdata);
            #1;
            checkOutput($sformatf("v%0d gnt", i),    128'(gnt_w[0]), 128'(tbl[i].exp_gnt));
            checkOutput($sformatf("v%0d req_o", i),  128'(req_w[0]), 128'(tbl[i].exp_req));
            checkOutput($sformatf("v%0d add", i),    128'(add_w[0]), 128'(tbl[i].exp_add));
            checkOutput($sformatf("v%0d vld", i),    128'(vld_w[0]), 128'(tbl[i].exp_vld));
            checkOutput($sformatf("v%0d rdata", i),  rdata_w[0], expRdata(tbl[i].exp_vld, tbl[i].rdata));
            checkOutput($sformatf("v%0d vld B", i),  128'(vld_w[1]), 128'(tbl[i].exp_vld));
            tick();
        end

        // Master 1 store: acknowledged only by the WriteRespEn=1 instance.
        applyStimulus(4'b0010, 1'b1, 4'b0010, '0);
        #1;
        checkOutput("wr gnt",   128'(gnt_w[0]),   128'(4'b0010));
        checkOutput("wr wen",   128'(wen_w[0]),   128'(1'b1));
        checkOutput("wr wdata", 128'(wdata_w[0]), 128'(32'hA000_0001));
        checkOutput("wr be",    128'(be_w[0]),    128'(4'h2));
        checkOutput("wr gnt B", 128'(gnt_w[1]),   128'(4'b0010));
        tick();
        applyStimulus('0, 1'b1, '0, 32'h5555_AAAA);
        #1;
        checkOutput("wr vld A",   128'(vld_w[0]), 128'(4'b0010));
        checkOutput("wr rdata A", rdata_w[0],     expRdata(4'b0010, 32'h5555_AAAA));
        checkOutput("wr vld B",   128'(vld_w[1]), '0);
        checkOutput("wr rdata B", rdata_w[1],     '0);
        tick();
        applyStimulus('0, 1'b1, '0, '0);
        #1;
        checkOutput("wr vld A after", 128'(vld_w[0]), '0);
        for (int i = 0; i < 4; i++) tick();

        // RespLat=3: masters 0, 3, 1 back-to-back.
        applyStimulus(4'b0001, 1'b1, '0, '0);
        #1;
        checkOutput("pl gnt0", 128'(gnt_w[2]), 128'(4'b0001));
        tick();
        applyStimulus(4'b1000, 1'b1, '0, '0);
        #1;
        checkOutput("pl gnt3", 128'(gnt_w[2]), 128'(4'b1000));
        checkOutput("pl vld t+1", 128'(vld_w[2]), '0);
        tick();
        applyStimulus(4'b0010, 1'b1, '0, '0);
        #1;
        checkOutput("pl gnt1", 128'(gnt_w[2]), 128'(4'b0010));
        checkOutput("pl vld t+2", 128'(vld_w[2]), '0);
        tick();
        applyStimulus('0, 1'b1, '0, 32'h1111_1111);
        #1;
        checkOutput("pl vld t+3",   128'(vld_w[2]), 128'(4'b0001));
        checkOutput("pl rdata t+3", rdata_w[2],     expRdata(4'b0001, 32'h1111_1111));
        tick();
        applyStimulus('0, 1'b1, '0, 32'h2222_2222);
        #1;
        checkOutput("pl vld t+4",   128'(vld_w[2]), 128'(4'b1000));
        checkOutput("pl rdata t+4", rdata_w[2],     expRdata(4'b1000, 32'h2222_2222));
        tick();
        applyStimulus('0, 1'b1, '0, 32'h3333_3333);
        #1;
        checkOutput("pl vld t+5",   128'(vld_w[2]), 128'(4'b0010));
        checkOutput("pl rdata t+5", rdata_w[2],     expRdata(4'b0010, 32'h3333_3333));
        tick();
        applyStimulus('0, 1'b1, '0, '0);
        #1;
        checkOutput("pl vld t+6", 128'(vld_w[2]), '0);
        for (int i = 0; i < 3; i++) tick();

        // RespLat=2: reset lands while the master-0 read is in flight.
        applyStimulus(4'b0001, 1'b1, '0, '0);
        #1;
        checkOutput("rst gnt pre", 128'(gnt_w[3]), 128'(4'b0001));
        tick();
        applyStimulus('0, 1'b1, '0, 32'h7777_7777);
        rst_n = 1'b0;
        #1;
        checkOutput("rst vld during", 128'(vld_w[3]), '0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("rst vld t+2",   128'(vld_w[3]), '0);
        checkOutput("rst rdata t+2", rdata_w[3],     '0);
        tick();
        checkOutput("rst vld t+3", 128'(vld_w[3]), '0);
        applyStimulus(4'b1111, 1'b1, '0, 32'h8888_8888);
        #1;
        checkOutput("rst gnt post D", 128'(gnt_w[3]), 128'(4'b0001));
        checkOutput("rst gnt post A", 128'(gnt_w[0]), 128'(4'b0001));
        tick();
        applyStimulus('0, 1'b1, '0, 32'h8888_8888);
        #1;
        checkOutput("rst post vld t+1", 128'(vld_w[3]), '0);
        tick();
        #1;
        checkOutput("rst post vld t+2",   128'(vld_w[3]), 128'(4'b0001));
        checkOutput("rst post rdata t+2", rdata_w[3],     expRdata(4'b0001, 32'h8888_8888));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_rr_arbiter.md
Name: tcdm_bank_rr_arbiter

Overview:
- Shares one single-ported TCDM bank between NumIn masters, using a round-robin priority pointer.
- Forwards the winning request to the bank and returns that master's grant combinationally.
- Routes the bank response back to the originating master after a fixed bank read latency.
- Serves as the per-bank arbitration stage of a LIC-style crossbar, and can be used standalone to share private memories.

Parameters:
- NumIn, 4: number of requesting masters (>=1).
- AddrMemWidth, 12: bank word-address width.
- DataWidth, 32: data width; byte enable width is DataWidth/8.
- RespLat, 1: bank read latency in cycles (>=1).
- WriteRespEn, 1: 1 = writes also produce vld_o; 0 = only reads do.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumIn  master request.
- add_i  in  NumIn x AddrMemWidth  master word address.
- wen_i  in  NumIn  1 = store, 0 = load.
- wdata_i  in  NumIn x DataWidth  write data.
- be_i  in  NumIn x DataWidth/8  byte enables.
- gnt_o  out  NumIn  master grant (combinational).
- vld_o  out  NumIn  response valid.
- rdata_o  out  NumIn x DataWidth  response data.
- req_o  out  1  bank request.
- gnt_i  in  1  bank grant/ready.
- add_o  out  AddrMemWidth  bank address.
- wen_o  out  1  bank store/load.
- wdata_o  out  DataWidth  bank write data.
- be_o  out  DataWidth/8  bank byte enables.
- rdata_i  in  DataWidth  bank read data, valid RespLat cycles after handshake.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- State: rr_q (priority pointer, width max(1,$clog2(NumIn))) and a RespLat-deep response pipe; each stage holds {valid, idx, is_write}.
- Winner selection (combinational):
  - Winner = first index with req_i set, searching cyclically from rr_q through rr_q+NumIn-1 mod NumIn.
  - req_o = |req_i.
  - add_o, wen_o, wdata_o, be_o = the winner's fields.
  - When req_i = 0, the bank fields are don't-care; the implementation drives the index-0 fields.
- Handshake = req_o & gnt_i.
  - gnt_o[winner] = gnt_i & req_o; all other gnt_o bits are 0.
  - No gnt_o bit is ever high without the matching req_i.
- Pointer update: on a handshake, rr_q <= (winner+1) mod NumIn. Otherwise rr_q holds.
  - A stalled bank (gnt_i=0) therefore does not rotate priority.
- Masters may change or withdraw a request while not granted. No request-stability check is performed.
- Response pipe:
  - Stage 0 loads {handshake, winner, wen_o} every cycle.
  - Stages shift by one each cycle, unconditionally; there is no backpressure on responses.
  - At the last stage, with valid set and (!is_write | WriteRespEn): vld_o[idx]=1 and rdata_o[idx]=rdata_i.
  - All other vld_o bits are 0 and all other rdata_o lanes are 0.
- Latency: vld_o rises exactly RespLat cycles after the handshake cycle.
- Throughput: one transaction per cycle, back-to-back, with responses in order.
- Write with WriteRespEn=0: no vld_o, and the rdata_o lane for that master stays 0.
- Reset values:
  - rr_q=0 and all pipe stages invalid.
  - vld_o=0 and rdata_o=0.
  - Combinational outputs follow their inputs; with req_i=0, req_o=0 and gnt_o=0.
- Reset mid-operation: all in-flight responses are discarded and no vld_o fires after reset release for transactions issued before reset.
- NumIn=1: rr_q is a constant 0 and the block degenerates to a pass-through with a response delay line.
- Simultaneous handshake and response in one cycle: fully independent. A new request may be granted in the same cycle a previous response is returned, for the same master or another.
- Assertions (simulation only):
  - $onehot0(gnt_o).
  - gnt_o implies req_i.
  - No vld_o without a prior handshake RespLat cycles earlier.

Test Plan:
- Fairness, all requesting: NumIn=4, req_i=4'b1111 held, gnt_i=1 for 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Bank stall: req_i=4'b0110 with gnt_i=0 for 3 cycles, then gnt_i=1 -> gnt_o=0 during the stall. Then gnt_o=0010, then 0100, and rr_q=3 after the second grant.
- Read response: master 2 loads add=0x05, RespLat=1, bank returns 0xDEADBEEF -> vld_o=4'b0100 and rdata_o[2]=0xDEADBEEF exactly one cycle after the grant. All other lanes are 0.
- Write response control: master 1 stores with WriteRespEn=0 -> vld_o stays 0. Repeated with WriteRespEn=1 -> vld_o=4'b0010 one cycle later.
- Pipelined latency: RespLat=3, masters 0,3,1 granted on consecutive cycles with reads -> vld_o = 0001,1000,0010 on cycles t+3, t+4, t+5, each with its own rdata_i.
- Reset mid-flight: RespLat=2, grant master 0, assert rst_ni=0 in the next cycle for 1 cycle -> no vld_o afterwards and rr_q=0, so master 0 wins first after reset.
